// File: rtl/alarm_pkg.sv
// Shared types and BCD time helpers for the multi-channel alarm clock.
package alarm_pkg;

  typedef struct packed {
    logic [3:0] hour_tens;
    logic [3:0] hour_ones;
    logic [3:0] min_tens;
    logic [3:0] min_ones;
  } bcd_time_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RING   = 2'd1,
    ST_SNOOZE = 2'd2
  } chan_state_t;

  function automatic logic bcd_valid(input bcd_time_t t);
    logic ok;
    ok = (t.hour_tens <= 4'd2) && (t.hour_ones <= 4'd9) &&
         (t.min_tens <= 4'd5) && (t.min_ones <= 4'd9);
    if ((t.hour_tens == 4'd2) && (t.hour_ones > 4'd3)) ok = 1'b0;
    return ok;
  endfunction

  // Adds n minutes (n < 60) with a 24 h wrap, going through a minute-of-day count.
  function automatic bcd_time_t bcd_add_min(input bcd_time_t t, input logic [5:0] n);
    logic [10:0] total;
    logic [4:0]  hh;
    logic [5:0]  mm;
    bcd_time_t   r;
    total = 11'(t.hour_tens) * 11'd600 + 11'(t.hour_ones) * 11'd60 +
            11'(t.min_tens) * 11'd10 + 11'(t.min_ones) + 11'(n);
    if (total >= 11'd1440) total = total - 11'd1440;
    hh = 5'(total / 11'd60);
    mm = 6'(total % 11'd60);
    r.hour_tens = 4'(hh / 5'd10);
    r.hour_ones = 4'(hh % 5'd10);
    r.min_tens  = 4'(mm / 6'd10);
    r.min_ones  = 4'(mm % 6'd10);
    return r;
  endfunction

endpackage

// File: rtl/alarm_channel.sv
// One alarm channel: stored alarm time, snooze target, ring timer and IDLE/RING/SNOOZE FSM.
module alarm_channel
  import alarm_pkg::*;
#(
  parameter int RING_SEC   = 60,
  parameter int SNOOZE_MIN = 5
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      en,
  input  logic      wr,
  input  bcd_time_t wr_time,
  input  logic      sec_tick,
  input  logic      minute_adv,
  input  bcd_time_t now_time,
  input  bcd_time_t next_time,
  input  logic      snooze,
  input  logic      dismiss,
  output logic      ring
);

  chan_state_t state_reg;
  logic [7:0]  cnt_reg;
  bcd_time_t   alarm_reg;
  bcd_time_t   snooze_reg;
  logic        alarm_hit;
  logic        snooze_hit;

  // Matches look at the time being loaded this edge so ring rises together with time_now.
  assign alarm_hit  = minute_adv && (next_time == alarm_reg);
  assign snooze_hit = minute_adv && (next_time == snooze_reg);
  assign ring       = (state_reg == ST_RING);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= ST_IDLE;
      cnt_reg    <= '0;
      alarm_reg  <= '0;
      snooze_reg <= '0;
    end else begin
      if (wr) alarm_reg <= wr_time;
      if (!en) begin
        state_reg <= ST_IDLE;
        cnt_reg   <= '0;
      end else begin
        case (state_reg)
          ST_IDLE: begin
            if (alarm_hit) begin
              state_reg <= ST_RING;
              cnt_reg   <= '0;
            end
          end
          ST_RING: begin
            if (dismiss) begin
              state_reg <= ST_IDLE;
            end else if (snooze) begin
              state_reg  <= ST_SNOOZE;
              snooze_reg <= bcd_add_min(now_time, 6'(SNOOZE_MIN));
            end else if (alarm_hit) begin
              cnt_reg <= '0;
            end else if (sec_tick) begin
              if (cnt_reg == 8'(RING_SEC - 1)) state_reg <= ST_IDLE;
              else cnt_reg <= cnt_reg + 8'd1;
            end
          end
          ST_SNOOZE: begin
            if (dismiss) begin
              state_reg <= ST_IDLE;
            end else if (snooze_hit) begin
              state_reg <= ST_RING;
              cnt_reg   <= '0;
            end
          end
          default: state_reg <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: rtl/alarm_multi_core.sv
// Time-of-day clock (prescaler, seconds, BCD HH:MM) driving N_ALARM independent alarm channels.
module alarm_multi_core
  import alarm_pkg::*;
#(
  parameter int TICK_DIV   = 100000000,
  parameter int N_ALARM    = 4,
  parameter int RING_SEC   = 60,
  parameter int SNOOZE_MIN = 5,
  localparam int IDX_W     = (N_ALARM > 1) ? $clog2(N_ALARM) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               time_load,
  input  logic [15:0]        time_init,
  input  logic               alarm_wr,
  input  logic [IDX_W-1:0]   alarm_idx,
  input  logic [15:0]        alarm_time,
  input  logic [N_ALARM-1:0] alarm_en,
  input  logic               snooze,
  input  logic               dismiss,
  output logic [15:0]        time_now,
  output logic [5:0]         sec_now,
  output logic               sec_tick,
  output logic [N_ALARM-1:0] ring,
  output logic               aud_en
);

  localparam int PRE_W = $clog2(TICK_DIV);

  logic [PRE_W-1:0] presc_reg;
  logic [5:0]       sec_reg;
  bcd_time_t        time_reg;
  bcd_time_t        next_time;
  logic             load_ok;
  logic             minute_adv;
  logic             wr_ok;

  assign sec_tick   = (presc_reg == PRE_W'(TICK_DIV - 1));
  assign load_ok    = time_load && bcd_valid(bcd_time_t'(time_init));
  // A valid load takes precedence, so a coincident tick never produces a minute advance.
  assign minute_adv = sec_tick && (sec_reg == 6'd59) && !load_ok;
  assign next_time  = bcd_add_min(time_reg, 6'd1);
  assign wr_ok      = alarm_wr && bcd_valid(bcd_time_t'(alarm_time)) &&
                      (32'(alarm_idx) < N_ALARM);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_reg <= '0;
      sec_reg   <= '0;
      time_reg  <= '0;
    end else if (load_ok) begin
      presc_reg <= '0;
      sec_reg   <= '0;
      time_reg  <= bcd_time_t'(time_init);
    end else begin
      presc_reg <= sec_tick ? '0 : presc_reg + 1'b1;
      if (sec_tick) begin
        if (sec_reg == 6'd59) begin
          sec_reg  <= '0;
          time_reg <= next_time;
        end else begin
          sec_reg <= sec_reg + 6'd1;
        end
      end
    end
  end

  generate
    for (genvar gi = 0; gi < N_ALARM; gi++) begin : g_chan
      alarm_channel #(
        .RING_SEC   (RING_SEC),
        .SNOOZE_MIN (SNOOZE_MIN)
      ) u_chan (
        .clk        (clk),
        .rst        (rst),
        .en         (alarm_en[gi]),
        .wr         (wr_ok && (alarm_idx == IDX_W'(gi))),
        .wr_time    (bcd_time_t'(alarm_time)),
        .sec_tick   (sec_tick),
        .minute_adv (minute_adv),
        .now_time   (time_reg),
        .next_time  (next_time),
        .snooze     (snooze),
        .dismiss    (dismiss),
        .ring       (ring[gi])
      );
    end
  endgenerate

  assign time_now = time_reg;
  assign sec_now  = sec_reg;
  assign aud_en   = |ring;

endmodule

// File: tb/tb_alarm_multi_core.sv
// Directed bench for alarm_multi_core with a 4-cycle second and 3-second ring time.
module tb_alarm_multi_core;

  logic        clk = 1'b0;
  logic        rst;
  logic        time_load;
  logic [15:0] time_init;
  logic        alarm_wr;
  logic [1:0]  alarm_idx;
  logic [15:0] alarm_time;
  logic [3:0]  alarm_en;
  logic        snooze;
  logic        dismiss;
  logic [15:0] time_now;
  logic [5:0]  sec_now;
  logic        sec_tick;
  logic [3:0]  ring;
  logic        aud_en;

  int total = 0;
  int bad   = 0;

  alarm_multi_core #(
    .TICK_DIV   (4),
    .N_ALARM    (4),
    .RING_SEC   (3),
    .SNOOZE_MIN (5)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .time_load  (time_load),
    .time_init  (time_init),
    .alarm_wr   (alarm_wr),
    .alarm_idx  (alarm_idx),
    .alarm_time (alarm_time),
    .alarm_en   (alarm_en),
    .snooze     (snooze),
    .dismiss    (dismiss),
    .time_now   (time_now),
    .sec_now    (sec_now),
    .sec_tick   (sec_tick),
    .ring       (ring),
    .aud_en     (aud_en)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      $display("check %s ok: 0x%0h", tag, obs);
    end else begin
      bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [15:0] t);
    time_init = t;
    time_load = 1'b1;
    step(1);
    time_load = 1'b0;
  endtask

  task automatic write_alarm(input logic [1:0] idx, input logic [15:0] t);
    alarm_idx  = idx;
    alarm_time = t;
    alarm_wr   = 1'b1;
    step(1);
    alarm_wr   = 1'b0;
  endtask

  initial begin
    rst = 1'b1; time_load = 1'b0; time_init = '0; alarm_wr = 1'b0; alarm_idx = '0;
    alarm_time = '0; alarm_en = '0; snooze = 1'b0; dismiss = 1'b0;
    #3;
    check("rst_time", time_now, 16'h0000);
    check("rst_sec", sec_now, 6'd0);
    check("rst_tick", sec_tick, 1'b0);
    check("rst_ring", ring, 4'b0000);
    check("rst_aud", aud_en, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    step(2);

    // Rollover 23:59 -> 00:00 and tick cadence
    load(16'h2359);
    check("load_time", time_now, 16'h2359);
    check("load_tick", sec_tick, 1'b0);
    step(3);
    check("tick_hi", sec_tick, 1'b1);
    step(1);
    check("tick_lo", sec_tick, 1'b0);
    check("sec_one", sec_now, 6'd1);
    step(236);
    check("wrap_time", time_now, 16'h0000);
    check("wrap_sec", sec_now, 6'd0);

    // Alarm0 at 07:30, ring and auto-off
    alarm_en = 4'b0001;
    write_alarm(2'd0, 16'h0730);
    load(16'h0729);
    step(239);
    check("pre_time", time_now, 16'h0729);
    check("pre_sec", sec_now, 6'd59);
    check("pre_ring", ring, 4'b0000);
    step(1);
    check("a0_ring", ring, 4'b0001);
    check("a0_aud", aud_en, 1'b1);
    check("a0_time", time_now, 16'h0730);
    step(11);
    check("a0_still", ring, 4'b0001);
    step(1);
    check("a0_off", ring, 4'b0000);
    check("a0_aud_off", aud_en, 1'b0);

    // Snooze across midnight
    alarm_en = 4'b0011;
    write_alarm(2'd1, 16'h2357);
    load(16'h2356);
    step(240);
    check("a1_ring", ring, 4'b0010);
    check("a1_time", time_now, 16'h2357);
    snooze = 1'b1; step(1); snooze = 1'b0;
    check("snz_ring", ring, 4'b0000);
    check("snz_aud", aud_en, 1'b0);
    step(1198);
    check("snz_wait_t", time_now, 16'h0001);
    check("snz_wait_r", ring, 4'b0000);
    step(1);
    check("rering_t", time_now, 16'h0002);
    check("rering_r", ring, 4'b0010);
    dismiss = 1'b1; step(1); dismiss = 1'b0;
    check("dis_ring", ring, 4'b0000);

    // Ch2 snoozed, ch1 ringing, snooze+dismiss together
    alarm_en = 4'b0110;
    write_alarm(2'd2, 16'h1000);
    write_alarm(2'd1, 16'h1001);
    load(16'h0959);
    step(240);
    check("c2_ring", ring, 4'b0100);
    snooze = 1'b1; step(1); snooze = 1'b0;
    check("c2_snz", ring, 4'b0000);
    step(239);
    check("c1_ring", ring, 4'b0010);
    check("c1_time", time_now, 16'h1001);
    snooze = 1'b1; dismiss = 1'b1; step(1); snooze = 1'b0; dismiss = 1'b0;
    check("both_ring", ring, 4'b0000);
    check("both_aud", aud_en, 1'b0);
    step(959);
    check("c2_tgt_t", time_now, 16'h1005);
    check("c2_tgt_r", ring, 4'b0000);
    step(240);
    check("c1_tgt_t", time_now, 16'h1006);
    check("c1_tgt_r", ring, 4'b0000);

    // Load onto alarm time, invalid load
    alarm_en = 4'b0001;
    load(16'h0730);
    check("ld_eq_t", time_now, 16'h0730);
    check("ld_eq_r", ring, 4'b0000);
    load(16'h2500);
    check("ld_bad_t", time_now, 16'h0730);
    step(4);
    check("ld_bad_s", sec_now, 6'd1);
    check("ld_bad_r", ring, 4'b0000);

    // Enable drop forces idle
    load(16'h0729);
    step(240);
    check("en_ring", ring, 4'b0001);
    alarm_en = 4'b0000; step(1);
    check("en_off", ring, 4'b0000);
    alarm_en = 4'b0001; step(1);
    check("en_back", ring, 4'b0000);

    // Async reset mid-ring
    load(16'h0729);
    step(240);
    check("r_ring", ring, 4'b0001);
    #2 rst = 1'b1;
    #1;
    check("ar_ring", ring, 4'b0000);
    check("ar_aud", aud_en, 1'b0);
    check("ar_time", time_now, 16'h0000);
    check("ar_sec", sec_now, 6'd0);
    check("ar_tick", sec_tick, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    step(2);
    check("post_ring", ring, 4'b0000);
    check("post_time", time_now, 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
